// File: rtl/hyperbus_pkg.sv
// -----------------------------------------------------------------------------
// hyperbus_pkg
// Shared definitions for the HyperBus write path.
//   NumPhys             number of 16-bit PHY lanes (1 or 2)
//   PhyBytes            bytes per PHY word (2*NumPhys)
//   MaxBusBytes         widest AXI bus supported by beat_byte_mask (1024 bits)
//   hyper_w2phy_state_t write packer FSM states
//   beat_byte_mask()    byte lanes that an AXI beat at (addr,size) may write
// -----------------------------------------------------------------------------
package hyperbus_pkg;

    localparam int unsigned NumPhys     = 2;
    localparam int unsigned PhyBytes    = 2 * NumPhys;
    localparam int unsigned MaxBusBytes = 128;

    typedef enum logic [1:0] {
        W2P_IDLE     = 2'd0,
        W2P_WAIT_AXI = 2'd1,
        W2P_SEND     = 2'd2
    } hyper_w2phy_state_t;

    // Bytes from addr up to the end of the size-aligned container holding addr.
    // Lanes below an unaligned start address are excluded.
    function automatic logic [MaxBusBytes-1:0] beat_byte_mask(input logic [7:0] addr,
                                                               input logic [2:0] size);
        logic [MaxBusBytes-1:0] mask;
        logic [8:0]             lo;
        logic [8:0]             hi;
        mask = '0;
        lo   = {1'b0, addr};
        hi   = ((lo >> size) << size) + (9'd1 << size);
        for (int i = 0; i < MaxBusBytes; i++) begin
            mask[i] = (9'(i) >= lo) && (9'(i) < hi);
        end
        return mask;
    endfunction

endpackage

// File: rtl/hyperbus_w2phy.sv
// -----------------------------------------------------------------------------
// hyperbus_w2phy
// Packs AXI W beats (full, narrow or unaligned) into PHY words of 16*NumPhys
// bits with byte strobes for the PHY/CDC write FIFO. Mirror of the read-path
// splitter.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   trans_handshake_i            new transaction accepted (1-cycle pulse)
//   is_a_write_i                 the accepted transaction is a write
//   start_addr_i                 start byte offset within the bus word
//   size_i                       AXI size (log2 bytes per beat)
//   burst_len_i                  AXI len (beats-1), only used for len_err_o
//   axi_valid_i/axi_ready_o      W channel handshake
//   axi_data_i/strb_i/last_i     W channel payload
//   phy_valid_o/phy_ready_i      PHY word handshake
//   phy_data_o/strb_o/last_o     PHY word, byte mask (1 = write), final word
//   len_err_o                    pulse: axi_last_i disagreed with burst_len_i
// -----------------------------------------------------------------------------
module hyperbus_w2phy
    import hyperbus_pkg::*;
#(
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned BurstLength  = 9,
    parameter int unsigned AddrWidth    = $clog2(AxiDataWidth / 8)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      trans_handshake_i,
    input  logic                      is_a_write_i,
    input  logic [AddrWidth-1:0]      start_addr_i,
    input  logic [2:0]                size_i,
    input  logic [BurstLength-1:0]    burst_len_i,
    input  logic                      axi_valid_i,
    output logic                      axi_ready_o,
    input  logic [AxiDataWidth-1:0]   axi_data_i,
    input  logic [AxiDataWidth/8-1:0] axi_strb_i,
    input  logic                      axi_last_i,
    output logic                      phy_valid_o,
    input  logic                      phy_ready_i,
    output logic [16*NumPhys-1:0]     phy_data_o,
    output logic [2*NumPhys-1:0]      phy_strb_o,
    output logic                      phy_last_o,
    output logic                      len_err_o
);

    localparam int unsigned AxiBytes = AxiDataWidth / 8;
    localparam int unsigned PhyWidth = 16 * NumPhys;
    localparam int unsigned CntW     = BurstLength + AddrWidth;
    localparam int unsigned PhyLsb   = $clog2(PhyBytes);
    localparam int unsigned IdxW     = AddrWidth - PhyLsb;
    localparam logic [2:0]  MaxSize  = 3'(AddrWidth);

    hyper_w2phy_state_t      state_r, state_s;
    logic [2:0]              size_r;
    logic [CntW-1:0]         axi_addr_r;
    logic [CntW-1:0]         phy_cnt_r;
    logic [BurstLength-1:0]  beats_left_r;
    logic                    last_beat_r;
    logic                    len_err_r;
    logic [AxiDataWidth-1:0] buf_data_r, buf_data_s;
    logic [AxiBytes-1:0]     buf_strb_r, buf_strb_s;

    logic                    start_s;
    logic                    axi_ready_s;
    logic                    axi_hs_s;
    logic                    phy_valid_s;
    logic                    phy_last_s;
    logic                    phy_hs_s;
    logic [7:0]              mask_addr_s;
    logic [MaxBusBytes-1:0]  mask_full_s;
    logic [AxiBytes-1:0]     beat_mask_s;
    logic                    unused_mask_s;
    logic [CntW-1:0]         next_addr_s;
    logic [CntW:0]           word_end_s;
    logic [IdxW-1:0]         phy_idx_s;
    logic [PhyWidth-1:0]     phy_data_s;
    logic [PhyBytes-1:0]     phy_strb_s;

    // Handshake qualifiers and beat geometry.
    always_comb begin
        start_s       = (state_r == W2P_IDLE) & trans_handshake_i & is_a_write_i;
        axi_ready_s   = (state_r == W2P_WAIT_AXI);
        axi_hs_s      = axi_ready_s & axi_valid_i;
        mask_addr_s   = '0;
        mask_addr_s[AddrWidth-1:0] = axi_addr_r[AddrWidth-1:0];
        mask_full_s   = beat_byte_mask(mask_addr_s, size_r);
        beat_mask_s   = mask_full_s[AxiBytes-1:0];
        unused_mask_s = ^mask_full_s[MaxBusBytes-1:AxiBytes];
        // Next beat starts at the end of the size-aligned container.
        next_addr_s   = ((axi_addr_r >> size_r) << size_r) + (CntW'(1) << size_r);
    end

    // PHY word selection: emit once a word is fully covered, or flush the
    // partial tail after the last beat.
    always_comb begin
        word_end_s  = {1'b0, phy_cnt_r} + (CntW + 1)'(PhyBytes);
        phy_idx_s   = phy_cnt_r[AddrWidth-1:PhyLsb];
        phy_valid_s = 1'b0;
        phy_last_s  = 1'b0;
        phy_data_s  = '0;
        phy_strb_s  = '0;
        if (state_r == W2P_SEND) begin
            phy_valid_s = (word_end_s <= {1'b0, axi_addr_r}) |
                          (last_beat_r & (phy_cnt_r < axi_addr_r));
            phy_last_s  = last_beat_r & (word_end_s >= {1'b0, axi_addr_r});
            phy_data_s  = buf_data_r[phy_idx_s*PhyWidth +: PhyWidth];
            phy_strb_s  = buf_strb_r[phy_idx_s*PhyBytes +: PhyBytes];
        end else begin
            phy_valid_s = 1'b0;
        end
        phy_hs_s = phy_valid_s & phy_ready_i;
    end

    // FSM next-state: Idle -> WaitAxi -> Send -> (WaitAxi | Idle).
    always_comb begin
        state_s = state_r;
        case (state_r)
            W2P_IDLE: begin
                if (start_s) state_s = W2P_WAIT_AXI;
                else         state_s = W2P_IDLE;
            end
            W2P_WAIT_AXI: begin
                if (axi_hs_s) state_s = W2P_SEND;
                else          state_s = W2P_WAIT_AXI;
            end
            W2P_SEND: begin
                if (!phy_valid_s)    state_s = W2P_WAIT_AXI;
                else if (!phy_ready_i) state_s = W2P_SEND;
                else if (phy_last_s) state_s = W2P_IDLE;
                else                 state_s = W2P_SEND;
            end
            default: state_s = W2P_IDLE;
        endcase
    end

    // Buffer next value: accepted beat overwrites its lanes, a sent word
    // releases its strobes, a new transaction starts from a clean mask.
    always_comb begin
        buf_data_s = buf_data_r;
        buf_strb_s = buf_strb_r;
        for (int i = 0; i < AxiBytes; i++) begin
            if (start_s) begin
                buf_strb_s[i] = 1'b0;
            end else if (axi_hs_s && beat_mask_s[i]) begin
                buf_data_s[i*8 +: 8] = axi_data_i[i*8 +: 8];
                buf_strb_s[i]        = axi_strb_i[i];
            end else if (phy_hs_s && (IdxW'(i / PhyBytes) == phy_idx_s)) begin
                buf_strb_s[i] = 1'b0;
            end else begin
                buf_strb_s[i] = buf_strb_r[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_r <= W2P_IDLE;
        else       state_r <= state_s;
    end

    // Buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_data_r <= '0;
            buf_strb_r <= '0;
        end else begin
            buf_data_r <= buf_data_s;
            buf_strb_r <= buf_strb_s;
        end
    end

    // Transaction counters and beat bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            size_r       <= 3'd0;
            axi_addr_r   <= '0;
            phy_cnt_r    <= '0;
            beats_left_r <= '0;
            last_beat_r  <= 1'b0;
        end else if (start_s) begin
            size_r       <= (size_i > MaxSize) ? MaxSize : size_i;
            axi_addr_r   <= CntW'(start_addr_i);
            phy_cnt_r    <= CntW'(start_addr_i) & ~CntW'(PhyBytes - 1);
            beats_left_r <= burst_len_i;
            last_beat_r  <= 1'b0;
        end else if (axi_hs_s) begin
            axi_addr_r   <= next_addr_s;
            beats_left_r <= beats_left_r - BurstLength'(1);
            last_beat_r  <= axi_last_i;
        end else if (phy_hs_s) begin
            phy_cnt_r    <= phy_cnt_r + CntW'(PhyBytes);
        end
    end

    // Length-mismatch pulse, one cycle after the offending beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) len_err_r <= 1'b0;
        else       len_err_r <= axi_hs_s & (axi_last_i != (beats_left_r == '0));
    end

    assign axi_ready_o = axi_ready_s;
    assign phy_valid_o = phy_valid_s;
    assign phy_data_o  = phy_data_s;
    assign phy_strb_o  = phy_strb_s;
    assign phy_last_o  = phy_last_s;
    assign len_err_o   = len_err_r;

endmodule
